hash_stream_core: RTL and testbench
===================================

// Module: hash_stream_core
// PURPOSE
//  Parametrised successor to the byte-serial DES-style hash core. Absorbs a message
//  of msg_len bytes over a valid/ready stream, LANES bytes per beat, iterated
//  compression into a DIGEST_W-bit chaining state, length-folded finalisation.
//  Sits between the message DMA/stream front-end and the digest consumer.
// PARAMETERS
//  LANES     1    bytes per input beat, 1..4; lane 0 = in_data[7:0] absorbed first
//  DIGEST_W  32   digest/state width, 32 or 64
//  ROUNDS    4    mixing rounds per byte, 1..8, all within one cycle
//  IV        64'h6A09E667F3BCC908   initial state, low DIGEST_W bits used
// PORTS
//  clk          in   1          clock
//  rst          in   1          synchronous reset, active-high
//  start        in   1          begin message; sampled only in IDLE or DONE
//  msg_len      in   64         message length in bytes, captured with start
//  in_valid     in   1          beat valid
//  in_data      in   8*LANES    message bytes
//  in_ready     out  1          beat accepted when in_valid & in_ready
//  busy         out  1          high in ABSORB, MIX, FINAL
//  digest_valid out  1          digest stable; held until next accepted start
//  digest       out  DIGEST_W   result
//  abort        in   1          only with HASH_ABORT_EN
// BEHAVIOUR
//  Reset: state IDLE; in_ready=0, busy=0, digest_valid=0, digest=0, counters 0.
//  mix(H,b): x=H^{DIGEST_W/8{b}}; ROUNDS times x=rotl(x,5)+(x>>3)+K, mod 2^DIGEST_W;
//   K=32'h9E3779B9 (DIGEST_W=32) / 64'h9E3779B97F4A7C15 (64).
//  FSM: IDLE/DONE -start-> H=IV, rem=msg_len; rem==0 ? FINAL : ABSORB.
//   ABSORB: in_ready=1; on accept H=mix(H,lane0), rem-=1; more valid lanes in beat
//    (rem>0 and lane<LANES) -> MIX, else rem==0 -> FINAL, else stay ABSORB.
//   MIX: in_ready=0; one lane per cycle in order; after last valid lane of the beat
//    -> ABSORB if rem>0, else FINAL.
//   FINAL: digest=mix(H^msg_len[DIGEST_W-1:0],8'h80); -> DONE, digest_valid=1.
//  Partial last beat: lanes beyond rem ignored, never absorbed.
//  LANES=1: in_ready continuous in ABSORB, one byte/cycle, no bubbles.
//  Latency: start edge to digest_valid = N+1 edges minimum (N=msg_len, LANES=1,
//   in_valid held high); empty message = 1 edge... FINAL then DONE (2 edges).
//  digest_valid drops the edge after start accepted in DONE; digest keeps old value
//   until next FINAL.
//  start while busy: ignored, no state change. in_valid outside ABSORB: ignored.
//  in_valid gaps in ABSORB: state and rem hold, digest unaffected by gap pattern.
//  rst mid-message: all outputs to reset values next edge; partial state discarded.
//  rem is 64-bit; no wrap; msg_len=2^64-1 legal.
// CONFIGURATION
//  HASH_ABORT_EN defined: abort port present; abort=1 in ABSORB/MIX/FINAL -> IDLE next
//   edge, busy=0, in_ready=0, digest_valid=0, digest unchanged; ignored in IDLE/DONE;
//   abort beats start in same cycle.
//  Not defined: no abort port; only rst terminates a message.
// TESTING
//  Empty: LANES=1, start msg_len=0 -> digest_valid exactly 2 edges later,
//   digest==model mix(IV,8'h80); in_ready never high.
//  One byte: msg_len=1, in_data=8'h41 -> digest_valid 2 edges after accept, ==model,
//   differs from empty digest.
//  Streaming: 756 bytes (i mod 256) back-to-back vs. 2 idle cycles between bytes ->
//   identical digest; back-to-back valid 757 edges after start; 755 bytes -> differs.
//  Lanes: LANES=4, msg_len=5, beats 32'h03020100, 32'hFFFFFF04 -> in_ready low 3
//   cycles after first beat, bytes FF ignored, digest == LANES=1 run of 00..04.
//  Reset/start: rst at byte 100 of 756 -> outputs 0 next edge, rerun matches clean
//   run; start pulsed while busy -> digest unchanged vs. no pulse.
//  HASH_ABORT_EN: abort at byte 10 -> IDLE next edge, busy=0; new msg_len=1 8'h41
//   gives one-byte digest.

Source files
------------

// File: rtl/hash_stream_core.sv
// hash_stream_core: streaming byte hash with iterated per-byte compression
// into a DIGEST_W-bit chaining state and length-folded finalisation.
// LANES bytes arrive per valid/ready beat; lane 0 (in_data[7:0]) is absorbed
// first, and the remaining lanes drain one per cycle in MIX.
// Optional feature: define HASH_ABORT_EN to add the abort port.
module hash_stream_core #(
    parameter int unsigned LANES    = 1,
    parameter int unsigned DIGEST_W = 32,
    parameter int unsigned ROUNDS   = 4,
    parameter logic [63:0] IV       = 64'h6A09E667F3BCC908
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [63:0]          msg_len,
    input  logic                 in_valid,
    input  logic [8*LANES-1:0]   in_data,
    output logic                 in_ready,
    output logic                 busy,
    output logic                 digest_valid,
    output logic [DIGEST_W-1:0]  digest
`ifdef HASH_ABORT_EN
    ,
    input  logic                 abort
`endif
);

    localparam logic [63:0] K64 = (DIGEST_W == 64) ? 64'h9E3779B97F4A7C15 : 64'h0000_0000_9E37_79B9;
    localparam logic [DIGEST_W-1:0] K = K64[DIGEST_W-1:0];
    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ABSORB, S_MIX, S_FINAL, S_DONE} state_t;

    function automatic logic [DIGEST_W-1:0] mix(input logic [DIGEST_W-1:0] h, input logic [7:0] b);
        logic [DIGEST_W-1:0] x;
        x = h ^ {(DIGEST_W/8){b}};
        for (int unsigned r = 0; r < ROUNDS; r++) begin
            x = {x[DIGEST_W-6:0], x[DIGEST_W-1:DIGEST_W-5]} + (x >> 3) + K;
        end
        return x;
    endfunction

    state_t                state, state_n;
    logic [DIGEST_W-1:0]   h, h_n;
    logic [63:0]           rem, rem_n, rem_dec;
    logic [DIGEST_W-1:0]   len, len_n;
    logic [8*LANES-1:0]    beat, beat_n;
    logic [LW-1:0]         lane, lane_n;
    logic [DIGEST_W-1:0]   digest_n;
    logic                  dv_n;
    logic                  abort_req;

`ifdef HASH_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign rem_dec = rem - 64'd1;

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            h            <= '0;
            rem          <= '0;
            len          <= '0;
            beat         <= '0;
            lane         <= '0;
            digest       <= '0;
            digest_valid <= 1'b0;
        end else begin
            state        <= state_n;
            h            <= h_n;
            rem          <= rem_n;
            len          <= len_n;
            beat         <= beat_n;
            lane         <= lane_n;
            digest       <= digest_n;
            digest_valid <= dv_n;
        end
    end

    // Next-state, datapath update and handshake outputs
    always_comb begin
        state_n  = state;
        h_n      = h;
        rem_n    = rem;
        len_n    = len;
        beat_n   = beat;
        lane_n   = lane;
        digest_n = digest;
        dv_n     = digest_valid;
        in_ready = 1'b0;
        busy     = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    h_n     = IV[DIGEST_W-1:0];
                    rem_n   = msg_len;
                    len_n   = msg_len[DIGEST_W-1:0];
                    dv_n    = 1'b0;
                    state_n = (msg_len == 64'd0) ? S_FINAL : S_ABSORB;
                end
            end
            S_ABSORB: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    h_n    = mix(h, in_data[7:0]);
                    rem_n  = rem_dec;
                    // Keep the unabsorbed lanes right-aligned so MIX always reads beat[7:0].
                    beat_n = in_data >> 8;
                    lane_n = LW'(1);
                    if (rem_dec == 64'd0) begin
                        state_n = S_FINAL;
                    end else if (LANES > 1) begin
                        state_n = S_MIX;
                    end
                end
            end
            S_MIX: begin
                busy   = 1'b1;
                h_n    = mix(h, beat[7:0]);
                beat_n = beat >> 8;
                rem_n  = rem_dec;
                lane_n = lane + LW'(1);
                if (rem_dec == 64'd0) begin
                    state_n = S_FINAL;
                end else if (lane == LW'(LANES - 1)) begin
                    state_n = S_ABSORB;
                end
            end
            S_FINAL: begin
                busy     = 1'b1;
                digest_n = mix(h ^ len, 8'h80);
                dv_n     = 1'b1;
                state_n  = S_DONE;
            end
            default: state_n = S_IDLE;
        endcase

        // Abort overrides whatever the active state computed, including FINAL's digest update.
        if (abort_req && busy) begin
            state_n  = S_IDLE;
            digest_n = digest;
            dv_n     = 1'b0;
        end
    end

endmodule

// File: tb/tb_hash_stream_core.sv
// Self-checking bench for hash_stream_core: a LANES=1 and a LANES=4 instance,
// directed message sequence, expected digests queued from a reference model.
module tb_hash_stream_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start1, valid1, ready1, busy1, dv1;
    logic [63:0] len1;
    logic [7:0]  data1;
    logic [31:0] dig1;
    logic        start4, valid4, ready4, busy4, dv4;
    logic [63:0] len4;
    logic [31:0] data4;
    logic [31:0] dig4;
`ifdef HASH_ABORT_EN
    logic        abort1, abort4;
`endif

    hash_stream_core #(.LANES(1), .DIGEST_W(32), .ROUNDS(4)) u1 (
        .clk(clk), .rst(rst), .start(start1), .msg_len(len1), .in_valid(valid1),
        .in_data(data1), .in_ready(ready1), .busy(busy1), .digest_valid(dv1), .digest(dig1)
`ifdef HASH_ABORT_EN
        , .abort(abort1)
`endif
    );

    hash_stream_core #(.LANES(4), .DIGEST_W(32), .ROUNDS(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .msg_len(len4), .in_valid(valid4),
        .in_data(data4), .in_ready(ready4), .busy(busy4), .digest_valid(dv4), .digest(dig4)
`ifdef HASH_ABORT_EN
        , .abort(abort4)
`endif
    );

    int total = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mmix(input logic [31:0] h, input logic [7:0] b);
        logic [31:0] x;
        x = h ^ {b, b, b, b};
        for (int r = 0; r < 4; r++) begin
            x = ((x << 5) | (x >> 27)) + (x >> 3) + 32'h9E3779B9;
        end
        return x;
    endfunction

    function automatic logic [31:0] model(input int n, input logic [7:0] base);
        logic [63:0] iv;
        logic [31:0] h;
        iv = 64'h6A09E667F3BCC908;
        h  = iv[31:0];
        for (int i = 0; i < n; i++) begin
            h = mmix(h, base + 8'(i));
        end
        return mmix(h ^ 32'(n), 8'h80);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send n bytes (base+i) to the LANES=1 instance with `gap` idle cycles after
    // each accepted byte; optionally pulse start at edge pulse_at while busy.
    task automatic send1(input int n, input logic [7:0] base, input int gap, input int pulse_at,
                         output int edges, output logic [31:0] dout, output bit saw_ready);
        int i;
        int gcnt;
        bit acc;
        logic [31:0] prev;
        prev = dig1;
        exp_q.push_back(model(n, base));
        start1 = 1'b1;
        len1   = 64'(n);
        valid1 = 1'b0;
        step();
        start1 = 1'b0;
        check("dv_drop_after_start", dv1, 1'b0);
        check("digest_hold_after_start", dig1, prev);
        i = 0;
        gcnt = 0;
        edges = 0;
        saw_ready = 1'b0;
        while (!dv1 && edges < 5000) begin
            if (ready1) saw_ready = 1'b1;
            if (i < n && gcnt == 0) begin
                valid1 = 1'b1;
                data1  = base + 8'(i);
            end else if (i >= n) begin
                valid1 = 1'b1;
                data1  = 8'hEE;
            end else begin
                valid1 = 1'b0;
            end
            start1 = (edges == pulse_at);
            if (start1) len1 = 64'd3;
            acc = valid1 && ready1 && (i < n);
            step();
            edges++;
            if (acc) begin
                i++;
                gcnt = gap;
            end else if (gcnt > 0) begin
                gcnt--;
            end
        end
        valid1 = 1'b0;
        start1 = 1'b0;
        if (!dv1) check("dv_timeout", dv1, 1'b1);
        dout = dig1;
        check("digest_scoreboard", dig1, exp_q.pop_front());
    endtask

    int e;
    int lowcnt;
    bit sr;
    bit acc4;
    logic [31:0] d_empty, d_one, dA, dB, dC, dD, dE, d5, prevd;

    initial begin
        rst = 1'b1;
        start1 = 1'b0; valid1 = 1'b0; len1 = '0; data1 = '0;
        start4 = 1'b0; valid4 = 1'b0; len4 = '0; data4 = '0;
`ifdef HASH_ABORT_EN
        abort1 = 1'b0; abort4 = 1'b0;
`endif
        step();
        step();
        check("rst_ready", ready1, 1'b0);
        check("rst_busy", busy1, 1'b0);
        check("rst_dv", dv1, 1'b0);
        check("rst_digest", dig1, 32'h0);
        check("rst_dv4", dv4, 1'b0);
        check("rst_digest4", dig4, 32'h0);
        rst = 1'b0;
        step();

        // Empty message
        send1(0, 8'h00, 0, -1, e, d_empty, sr);
        check("empty_latency", 64'(e), 64'd1);
        check("empty_no_ready", sr, 1'b0);

        // One byte
        send1(1, 8'h41, 0, -1, e, d_one, sr);
        check("one_latency", 64'(e), 64'd2);
        check("one_differs_empty", d_one != d_empty, 1'b1);

        // Streaming: back-to-back, gapped, shorter, start pulse while busy
        send1(756, 8'h00, 0, -1, e, dA, sr);
        check("b2b_latency", 64'(e), 64'd757);
        send1(756, 8'h00, 2, -1, e, dB, sr);
        check("gap_same_digest", dB, dA);
        send1(755, 8'h00, 0, -1, e, dC, sr);
        check("len755_differs", dC != dA, 1'b1);
        send1(756, 8'h00, 0, 50, e, dD, sr);
        check("busy_start_ignored", dD, dA);
        check("busy_start_latency", 64'(e), 64'd757);

        // Reset in the middle of a message
        start1 = 1'b1;
        len1   = 64'd756;
        step();
        start1 = 1'b0;
        valid1 = 1'b1;
        for (int k = 0; k < 100; k++) begin
            data1 = 8'(k);
            step();
        end
        valid1 = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", busy1, 1'b0);
        check("midrst_ready", ready1, 1'b0);
        check("midrst_dv", dv1, 1'b0);
        check("midrst_digest", dig1, 32'h0);
        send1(756, 8'h00, 0, -1, e, dE, sr);
        check("rerun_after_rst", dE, dA);

        // Four lanes: 5 bytes over a full and a partial beat
        exp_q.push_back(model(5, 8'h00));
        start4 = 1'b1;
        len4   = 64'd5;
        step();
        start4 = 1'b0;
        valid4 = 1'b1;
        data4  = 32'h03020100;
        acc4   = 1'b0;
        for (int t = 0; t < 20 && !acc4; t++) begin
            acc4 = ready4;
            step();
        end
        check("lanes_first_accept", acc4, 1'b1);
        valid4 = 1'b0;
        lowcnt = 0;
        while (!ready4 && lowcnt < 10) begin
            lowcnt++;
            step();
        end
        check("lanes_ready_low_cycles", 64'(lowcnt), 64'd3);
        valid4 = 1'b1;
        data4  = 32'hFFFFFF04;
        step();
        valid4 = 1'b0;
        for (int t = 0; t < 20 && !dv4; t++) step();
        check("lanes_dv", dv4, 1'b1);
        check("lanes_digest_scoreboard", dig4, exp_q.pop_front());
        send1(5, 8'h00, 0, -1, e, d5, sr);
        check("lanes_vs_single_lane", dig4, d5);

`ifdef HASH_ABORT_EN
        // Abort mid-message, then a fresh one-byte message
        prevd = dig1;
        start1 = 1'b1;
        len1   = 64'd756;
        step();
        start1 = 1'b0;
        valid1 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            data1 = 8'(k);
            step();
        end
        valid1 = 1'b0;
        abort1 = 1'b1;
        step();
        abort1 = 1'b0;
        check("abort_busy", busy1, 1'b0);
        check("abort_ready", ready1, 1'b0);
        check("abort_dv", dv1, 1'b0);
        check("abort_digest_kept", dig1, prevd);
        send1(1, 8'h41, 0, -1, e, dE, sr);
        check("abort_then_one_byte", dE, d_one);
`else
        prevd = '0;
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
